// File: rtl/spi_xfer_ctrl.sv
// SPI master transaction engine: on the control word's send bit it streams
// N+1 bytes from the data register file out over SPI mode 0. Each received
// byte goes back to the same address. It then clears send and raises done
// through the control register's second write port.
module spi_xfer_ctrl #(
   parameter int DIV    = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ctrl_in,
   input  logic [31:0]       rd_data,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wr_data,
   output logic              wr_data_en,
   output logic              wr2c,
   output logic              flag_out,
   output logic              new_out,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      STORE,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [7:0]        rx_q, rx_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        div_cnt_q, div_cnt_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              wr_data_en_q, wr_data_en_d;
   logic              wr2c_q, wr2c_d;
   logic              flag_q, flag_d;
   logic              new_q, new_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;

   // Only send, the byte count and the TX byte are meaningful to this block.
   logic unused_bits;
   assign unused_bits = ^{ctrl_in[31:16], ctrl_in[7:1], rd_data[31:8]};

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      addr_d       = addr_q;
      shreg_d      = shreg_q;
      rx_d         = rx_q;
      bit_cnt_d    = bit_cnt_q;
      div_cnt_d    = div_cnt_q;
      wr_data_d    = wr_data_q;
      wr_data_en_d = 1'b0;
      wr2c_d       = 1'b0;
      flag_d       = 1'b0;
      new_d        = 1'b0;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      cs_n_d       = cs_n_q;
      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            addr_d = '0;
            if (ctrl_in[0]) begin
               // Start strobe clears the done flag while keeping send set.
               n_d     = ADDR_W'(ctrl_in[15:8]);
               state_d = LOAD;
               cs_n_d  = 1'b0;
               wr2c_d  = 1'b1;
               new_d   = 1'b1;
            end
         end
         LOAD: begin
            shreg_d   = rd_data[7:0];
            mosi_d    = rd_data[7];
            bit_cnt_d = 3'd0;
            div_cnt_d = 8'd0;
            sclk_d    = 1'b0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (div_cnt_q == 8'(DIV - 1)) begin
               div_cnt_d = 8'd0;
               if (!sclk_q) begin
                  // Rising sclk: capture MISO.
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], miso};
               end else begin
                  // Falling sclk: present the next bit, or finish the byte.
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     state_d      = STORE;
                     wr_data_en_d = 1'b1;
                     wr_data_d    = {24'd0, rx_q};
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     shreg_d   = {shreg_q[6:0], 1'b0};
                     mosi_d    = shreg_q[6];
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         STORE: begin
            if (addr_q == n_q) begin
               state_d = DONE;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               wr2c_d  = 1'b1;
               flag_d  = 1'b1;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = LOAD;
            end
         end
         DONE: begin
            addr_d  = '0;
            mosi_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transfer at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         n_q          <= '0;
         addr_q       <= '0;
         shreg_q      <= 8'd0;
         rx_q         <= 8'd0;
         bit_cnt_q    <= 3'd0;
         div_cnt_q    <= 8'd0;
         wr_data_q    <= 32'd0;
         wr_data_en_q <= 1'b0;
         wr2c_q       <= 1'b0;
         flag_q       <= 1'b0;
         new_q        <= 1'b0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         addr_q       <= addr_d;
         shreg_q      <= shreg_d;
         rx_q         <= rx_d;
         bit_cnt_q    <= bit_cnt_d;
         div_cnt_q    <= div_cnt_d;
         wr_data_q    <= wr_data_d;
         wr_data_en_q <= wr_data_en_d;
         wr2c_q       <= wr2c_d;
         flag_q       <= flag_d;
         new_q        <= new_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
      end
   end

   assign addr       = addr_q;
   assign wr_data    = wr_data_q;
   assign wr_data_en = wr_data_en_q;
   assign wr2c       = wr2c_q;
   assign flag_out   = flag_q;
   assign new_out    = new_q;
   assign sclk       = sclk_q;
   assign mosi       = mosi_q;
   assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Testbench for spi_xfer_ctrl: two instances (DIV=4 and DIV=1) share a
// modelled control register and data register file. A selector picks which
// instance is exercised and observed.
module tb_spi_xfer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;          // 0: DIV=4 instance, 1: DIV=1 instance
   logic [1:0]  miso_mode;    // 0 loopback, 1 inverted loopback, 2 tied 0, 3 tied 1
   logic        sw_we;
   logic [31:0] sw_wdata;
   logic [31:0] ctrl_reg;
   logic [31:0] mem [256];

   logic [7:0]  addr_a, addr_b;
   logic [31:0] wr_data_a, wr_data_b, ctrl_a, ctrl_b, rd_a, rd_b;
   logic        wr_en_a, wr_en_b, wr2c_a, wr2c_b, flag_a, flag_b, new_a, new_b;
   logic        sclk_a, sclk_b, mosi_a, mosi_b, miso_a, miso_b, cs_a, cs_b;

   function automatic logic miso_of(input logic m, input logic [1:0] mode);
      case (mode)
         2'd0:    return m;
         2'd1:    return ~m;
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Reference: byte received for a transmitted byte under each MISO mode.
   function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [1:0] mode);
      case (mode)
         2'd0:    return tx;
         2'd1:    return ~tx;
         2'd2:    return 8'h00;
         default: return 8'hFF;
      endcase
   endfunction

   assign ctrl_a = sel ? 32'd0 : ctrl_reg;
   assign ctrl_b = sel ? ctrl_reg : 32'd0;
   assign rd_a   = mem[addr_a];
   assign rd_b   = mem[addr_b];
   assign miso_a = miso_of(mosi_a, miso_mode);
   assign miso_b = miso_of(mosi_b, miso_mode);

   spi_xfer_ctrl #(.DIV(4), .ADDR_W(8)) u_dut_div4 (
      .clk(clk), .rst(rst_n), .ctrl_in(ctrl_a), .rd_data(rd_a), .addr(addr_a),
      .wr_data(wr_data_a), .wr_data_en(wr_en_a), .wr2c(wr2c_a), .flag_out(flag_a),
      .new_out(new_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_a)
   );

   spi_xfer_ctrl #(.DIV(1), .ADDR_W(8)) u_dut_div1 (
      .clk(clk), .rst(rst_n), .ctrl_in(ctrl_b), .rd_data(rd_b), .addr(addr_b),
      .wr_data(wr_data_b), .wr_data_en(wr_en_b), .wr2c(wr2c_b), .flag_out(flag_b),
      .new_out(new_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_b)
   );

   logic [7:0]  addr_m;
   logic [31:0] wr_data_m;
   logic        wr_en_m, wr2c_m, flag_m, new_m, sclk_m, mosi_m, cs_m;
   assign addr_m    = sel ? addr_b    : addr_a;
   assign wr_data_m = sel ? wr_data_b : wr_data_a;
   assign wr_en_m   = sel ? wr_en_b   : wr_en_a;
   assign wr2c_m    = sel ? wr2c_b    : wr2c_a;
   assign flag_m    = sel ? flag_b    : flag_a;
   assign new_m     = sel ? new_b     : new_a;
   assign sclk_m    = sel ? sclk_b    : sclk_a;
   assign mosi_m    = sel ? mosi_b    : mosi_a;
   assign cs_m      = sel ? cs_b      : cs_a;

   // Control register model: software write wins over the engine's WR2C port.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ctrl_reg <= 32'd0;
      else if (sw_we)   ctrl_reg <= sw_wdata;
      else if (wr2c_m)  ctrl_reg[0] <= new_m;
   end

   // Monitor of the selected instance.
   int          cyc = 0;
   logic [7:0]  wq_addr[$];
   logic [31:0] wq_data[$];
   logic        bits_q[$];
   int          w2_cyc[$];
   logic        w2_flag[$];
   logic        w2_new[$];
   int          n_done = 0;
   int          cs_glitch = 0;
   logic        in_xfer = 1'b0;
   logic        sclk_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wr_en_m) begin
         wq_addr.push_back(addr_m);
         wq_data.push_back(wr_data_m);
      end
      if (sclk_m && !sclk_prev) bits_q.push_back(mosi_m);
      sclk_prev = sclk_m;
      if (wr2c_m) begin
         w2_cyc.push_back(cyc);
         w2_flag.push_back(flag_m);
         w2_new.push_back(new_m);
         if (flag_m) begin
            n_done  = n_done + 1;
            in_xfer = 1'b0;
         end else begin
            in_xfer = 1'b1;
         end
      end
      if (in_xfer && cs_m) cs_glitch = cs_glitch + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic clear_mon();
      wq_addr.delete();
      wq_data.delete();
      bits_q.delete();
      w2_cyc.delete();
      w2_flag.delete();
      w2_new.delete();
      n_done    = 0;
      cs_glitch = 0;
      in_xfer   = 1'b0;
   endtask

   task automatic sw_write(input logic [31:0] v);
      @(posedge clk);
      #1;
      sw_wdata = v;
      sw_we    = 1'b1;
      @(posedge clk);
      #1;
      sw_we    = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < limit; t++) begin
         @(posedge clk);
         if (n_done > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
   endtask

   task automatic test_reset();
      int bad;
      bad   = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cs_a, sclk_a, mosi_a, wr_en_a, wr2c_a, flag_a, new_a} !== 7'b1000000 ||
          addr_a !== 8'd0 || wr_data_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_div4: cs/sclk/mosi/en/wr2c/flag/new=%b addr=%h wr_data=%h, required 1000000/00/0",
                  {cs_a, sclk_a, mosi_a, wr_en_a, wr2c_a, flag_a, new_a}, addr_a, wr_data_a);
      end
      checks++;
      if ({cs_b, sclk_b, mosi_b, wr_en_b, wr2c_b, flag_b, new_b} !== 7'b1000000 ||
          addr_b !== 8'd0 || wr_data_b !== 32'd0) begin
         errors++;
         $display("FAIL reset_div1: cs/sclk/mosi/en/wr2c/flag/new=%b addr=%h wr_data=%h, required 1000000/00/0",
                  {cs_b, sclk_b, mosi_b, wr_en_b, wr2c_b, flag_b, new_b}, addr_b, wr_data_b);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_mon();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ({cs_a, sclk_a, mosi_a, wr_en_a, wr2c_a, flag_a, new_a} !== 7'b1000000 ||
             {cs_b, sclk_b, mosi_b, wr_en_b, wr2c_b, flag_b, new_b} !== 7'b1000000 ||
             addr_a !== 8'd0 || addr_b !== 8'd0 || wr_data_a !== 32'd0 || wr_data_b !== 32'd0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_hold: %0d cycles off reset values, required 0", bad);
      end
      checks++;
      if (wq_addr.size() !== 0 || w2_cyc.size() !== 0) begin
         errors++;
         $display("FAIL reset_strobes: writes=%0d wr2c=%0d, required 0/0", wq_addr.size(), w2_cyc.size());
      end
   endtask

   // One complete transfer on the selected instance, checked against the model.
   task automatic test_transfer(input bit s, input int n, input logic [1:0] mode, input string tag);
      int         div;
      bit         ok;
      logic [7:0] b;
      logic [7:0] tx;
      div       = s ? 1 : 4;
      sel       = s;
      miso_mode = mode;
      clear_mon();
      sw_write({16'd0, 8'(n), 8'h01});
      wait_done((n + 1) * (16 * div + 2) + 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s done_timeout: no done strobe, required one", tag);
         return;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wq_addr.size() !== n + 1) begin
         errors++;
         $display("FAIL %s write_count: got %0d, required %0d", tag, wq_addr.size(), n + 1);
      end
      for (int i = 0; i <= n && i < wq_addr.size(); i++) begin
         tx = mem[i][7:0];
         checks++;
         if (wq_addr[i] !== 8'(i) || wq_data[i] !== {24'd0, exp_rx(tx, mode)}) begin
            errors++;
            $display("FAIL %s write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                     tag, i, wq_addr[i], wq_data[i], 8'(i), {24'd0, exp_rx(tx, mode)});
         end
      end
      checks++;
      if (bits_q.size() !== 8 * (n + 1)) begin
         errors++;
         $display("FAIL %s mosi_bitcount: got %0d, required %0d", tag, bits_q.size(), 8 * (n + 1));
      end
      for (int i = 0; i <= n; i++) begin
         b = 8'd0;
         for (int j = 0; j < 8; j++)
            if (8 * i + j < bits_q.size()) b = {b[6:0], bits_q[8 * i + j]};
         checks++;
         if (b !== mem[i][7:0]) begin
            errors++;
            $display("FAIL %s mosi_byte[%0d]: got %b, required %b", tag, i, b, mem[i][7:0]);
         end
      end
      checks++;
      if (w2_cyc.size() !== 2) begin
         errors++;
         $display("FAIL %s wr2c_count: got %0d, required 2", tag, w2_cyc.size());
      end else begin
         checks++;
         if (w2_flag[0] !== 1'b0 || w2_new[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s start_strobe: flag=%b new=%b, required flag=0 new=1", tag, w2_flag[0], w2_new[0]);
         end
         checks++;
         if (w2_flag[1] !== 1'b1 || w2_new[1] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_strobe: flag=%b new=%b, required flag=1 new=0", tag, w2_flag[1], w2_new[1]);
         end
         checks++;
         if (w2_cyc[1] - w2_cyc[0] !== (n + 1) * (16 * div + 2)) begin
            errors++;
            $display("FAIL %s strobe_spacing: got %0d cycles, required %0d",
                     tag, w2_cyc[1] - w2_cyc[0], (n + 1) * (16 * div + 2));
         end
      end
      checks++;
      if (cs_glitch !== 0) begin
         errors++;
         $display("FAIL %s cs_n_continuous: high for %0d cycles mid-transfer, required 0", tag, cs_glitch);
      end
      checks++;
      if (ctrl_reg[0] !== 1'b0 || cs_m !== 1'b1 || addr_m !== 8'd0) begin
         errors++;
         $display("FAIL %s after_done: send=%b cs_n=%b addr=%h, required 0/1/00", tag, ctrl_reg[0], cs_m, addr_m);
      end
   endtask

   task automatic test_reset_midxfer();
      bit ok;
      sel       = 1'b0;
      miso_mode = 2'd0;
      fill_random();
      clear_mon();
      sw_write(32'h0000_0301);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         if (wq_addr.size() >= 1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midrst_first_byte: no write seen, required one");
         return;
      end
      // Now in byte 1's LOAD cycle; 38 more edges land in bit 4's high phase.
      repeat (38) @(posedge clk);
      #3;
      checks++;
      if (cs_m !== 1'b0 || sclk_m !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: cs_n=%b sclk=%b, required 0/1", cs_m, sclk_m);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (cs_m !== 1'b1 || sclk_m !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: cs_n=%b sclk=%b, required 1/0", cs_m, sclk_m);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (n_done !== 0 || w2_cyc.size() !== 1) begin
         errors++;
         $display("FAIL midrst_no_done: done strobes=%0d wr2c=%0d, required 0/1", n_done, w2_cyc.size());
      end
      checks++;
      if (wq_addr.size() !== 1 || cs_m !== 1'b1 || sclk_m !== 1'b0 || addr_m !== 8'd0) begin
         errors++;
         $display("FAIL midrst_idle: writes=%0d cs_n=%b sclk=%b addr=%h, required 1/1/0/00",
                  wq_addr.size(), cs_m, sclk_m, addr_m);
      end
   endtask

   task automatic test_n_change();
      bit ok;
      sel       = 1'b1;
      miso_mode = 2'd3;
      fill_random();
      clear_mon();
      sw_write(32'h0000_0201);
      repeat (10) @(posedge clk);
      sw_write(32'h0000_0701);
      wait_done(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL nchg_done: no done strobe, required one");
         return;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wq_addr.size() !== 3) begin
         errors++;
         $display("FAIL nchg_count: got %0d bytes, required 3", wq_addr.size());
      end else begin
         checks++;
         if (wq_addr[2] !== 8'd2 || wq_data[2] !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL nchg_last: addr=%h data=%h, required 02/000000FF", wq_addr[2], wq_data[2]);
         end
      end
   endtask

   initial begin
      sel       = 1'b0;
      miso_mode = 2'd0;
      sw_we     = 1'b0;
      sw_wdata  = 32'd0;
      fill_random();
      test_reset();

      // DIV=4, one byte 0xA5 with loopback.
      fill_random();
      mem[0][7:0] = 8'hA5;
      test_transfer(1'b0, 0, 2'd0, "loop_a5");

      // DIV=1, three bytes, MISO tied high.
      fill_random();
      mem[0][7:0] = 8'h01;
      mem[1][7:0] = 8'h80;
      mem[2][7:0] = 8'hFF;
      test_transfer(1'b1, 2, 2'd3, "tied1_n2");

      // MISO tied low.
      fill_random();
      test_transfer(1'b0, 0, 2'd2, "tied0_n0");

      // Randomized transfers.
      for (int k = 0; k < 4; k++) begin
         fill_random();
         test_transfer(1'(k), int'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), "random");
      end

      // Back-to-back transfers.
      fill_random();
      test_transfer(1'b1, 1, 2'd1, "b2b_first");
      test_transfer(1'b1, 3, 2'd0, "b2b_second");

      // Full 256-byte transfer: address runs 0..255 without wrapping.
      fill_random();
      test_transfer(1'b1, 255, 2'd1, "n255");

      test_n_change();
      test_reset_midxfer();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
